// File: rtl/pulp_sync_wedge_pkg.sv
// Shared types for the sync-wedge edge transmitter: request codes, FSM states
// and the request-to-target-level mapping.
package pulp_sync_wedge_pkg;

  // Request encoding on req_type_i
  typedef enum logic [1:0] {
    SET_LOW  = 2'b00,
    SET_HIGH = 2'b01,
    TOGGLE   = 2'b10,
    PULSE    = 2'b11
  } req_type_e;

  // Transmitter FSM states (prefixed to keep them apart from the request codes)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_HOLD  = 2'b10
  } tx_state_e;

  // Level the line should move to for a given request and current line level
  function automatic logic target_level(input req_type_e req, input logic cur);
    logic lvl;
    case (req)
      SET_LOW:  lvl = 1'b0;
      SET_HIGH: lvl = 1'b1;
      default:  lvl = ~cur;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/pulp_sync_wedge_tx.sv
// Serial edge transmitter: drives a registered level onto a single wire and
// holds every new level for HOLD_CYCLES enable ticks so a 3-flop remote
// synchronizer sees each edge. Accepts requests only while idle.
module pulp_sync_wedge_tx
  import pulp_sync_wedge_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [1:0] req_type_i,
  output logic       serial_o,
  output logic       r_edge_o,
  output logic       f_edge_o,
  output logic       busy_o
);

  localparam int unsigned     CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Fewer than 3 ticks could slip an edge past the remote 3-flop synchronizer
  generate
    if (HOLD_CYCLES < 3) begin : g_hold_check
      $error("pulp_sync_wedge_tx: HOLD_CYCLES must be >= 3");
    end
  endgenerate

  tx_state_e        r_state;
  tx_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_serial;
  logic             w_serial_nxt;
  logic             r_rise;
  logic             r_fall;
  req_type_e        w_req_type;
  logic             w_target;
  logic             w_expire;

  assign w_req_type = req_type_e'(req_type_i);
  assign w_target   = target_level(w_req_type, r_serial);
  assign w_expire   = en_i && (r_cnt == CNT_ONE);

  // Ready depends on state only, so there is no valid->ready combinational path
  assign req_ready_o = (r_state == ST_IDLE);
  assign busy_o      = (r_state != ST_IDLE);
  assign serial_o    = r_serial;
  assign r_edge_o    = r_rise;
  assign f_edge_o    = r_fall;

  // Next-state, next-level and hold-counter logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_serial_nxt = r_serial;
    case (r_state)
      ST_IDLE: begin
        // A request for the level already on the wire is consumed silently
        if (req_valid_i && (w_target != r_serial)) begin
          w_serial_nxt = w_target;
          w_cnt_nxt    = CNT_LOAD;
          w_state_nxt  = (w_req_type == PULSE) ? ST_PULSE : ST_HOLD;
        end
      end
      ST_PULSE: begin
        if (w_expire) begin
          // Second half of the pulse: return to the pre-pulse level and hold it
          w_serial_nxt = ~r_serial;
          w_cnt_nxt    = CNT_LOAD;
          w_state_nxt  = ST_HOLD;
        end else if (en_i) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_HOLD: begin
        // Counter is >= 1 in this state, so the decrement cannot wrap
        if (en_i) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
        if (w_expire) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter, line flop and edge strobes registered together
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_serial <= RESET_LEVEL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_serial <= w_serial_nxt;
      r_rise   <= w_serial_nxt & ~r_serial;
      r_fall   <= ~w_serial_nxt & r_serial;
    end
  end

endmodule

// File: tb/tb_pulp_sync_wedge_tx.sv
// Self-checking bench for pulp_sync_wedge_tx (HOLD_CYCLES=4, RESET_LEVEL=0):
// vector table, hand-written multi-cycle sequences, and randomized traffic
// against a tick-budget reference model.
module tb_pulp_sync_wedge_tx;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       vld = 1'b0;
  logic [1:0] typ = 2'b00;
  logic       rdy, ser, rise, fall, busy;
  logic [4:0] w_out;

  int n_cmp = 0;
  int n_err = 0;

  pulp_sync_wedge_tx #(.HOLD_CYCLES(H), .RESET_LEVEL(1'b0)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .req_valid_i (vld),
    .req_ready_o (rdy),
    .req_type_i  (typ),
    .serial_o    (ser),
    .r_edge_o    (rise),
    .f_edge_o    (fall),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // {serial, rise, fall, ready, busy}
  assign w_out = {ser, rise, fall, rdy, busy};

  typedef struct {
    logic       v;
    logic [1:0] t;
    logic       e;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic v, input logic [1:0] t, input logic e,
                              input logic [4:0] exp);
    vec_t r;
    r.v = v; r.t = t; r.e = e; r.exp = exp;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (serial,rise,fall,ready,busy)", nm, act, exp);
    end
  endtask

  // Apply inputs before the next rising edge; return at the following falling edge
  task automatic step(input logic v, input logic [1:0] t, input logic e);
    vld = v; typ = t; en = e;
    @(negedge clk);
  endtask

  task automatic do_reset();
    vld = 1'b0; typ = 2'b00; en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // PULSE from level 0 with en every cycle: high in cycles 1-4, ready in cycle 9
  task automatic pulse_scn(input string tag);
    logic [4:0] exp;
    for (int c = 0; c < 9; c++) begin
      step((c == 0), 2'b11, 1'b1);
      exp = {((c + 1) >= 1 && (c + 1) <= 4), (c + 1) == 1, (c + 1) == 5,
             (c + 1) >= 9, (c + 1) < 9};
      chk($sformatf("%s_c%0d", tag, c + 1), w_out, exp);
    end
  endtask

  // Reference model: remaining en ticks of the whole transaction
  int   m_left;
  logic m_lvl;
  logic m_pulse;

  initial begin
    logic [4:0] exp;
    logic prev, tgt, rv, re;
    logic [1:0] rt;

    // ---- reset behaviour ----
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold", w_out, 5'b00010);
    rst = 1'b0;
    step(1'b0, 2'b00, 1'b1);
    chk("rst_rel", w_out, 5'b00010);

    // ---- vector table (one row per cycle) ----
    tbl[0]  = mk(1, 2'b00, 1, 5'b00010);  // SET_LOW at level 0: no edge
    tbl[1]  = mk(1, 2'b01, 1, 5'b11001);  // SET_HIGH: rise
    tbl[2]  = mk(0, 2'b00, 1, 5'b10001);
    tbl[3]  = mk(0, 2'b00, 1, 5'b10001);
    tbl[4]  = mk(0, 2'b00, 1, 5'b10001);
    tbl[5]  = mk(0, 2'b00, 1, 5'b10010);  // ready back 4 cycles after edge
    tbl[6]  = mk(1, 2'b01, 1, 5'b10010);  // SET_HIGH at level 1: no edge
    tbl[7]  = mk(1, 2'b11, 1, 5'b00101);  // PULSE from 1: fall
    tbl[8]  = mk(0, 2'b00, 1, 5'b00001);
    tbl[9]  = mk(0, 2'b00, 0, 5'b00001);  // counter frozen
    tbl[10] = mk(0, 2'b00, 1, 5'b00001);
    tbl[11] = mk(0, 2'b00, 1, 5'b00001);
    tbl[12] = mk(0, 2'b00, 1, 5'b11001);  // pulse return: rise
    tbl[13] = mk(1, 2'b10, 1, 5'b10001);  // request ignored while busy
    tbl[14] = mk(1, 2'b00, 1, 5'b10001);
    tbl[15] = mk(0, 2'b00, 1, 5'b10001);
    tbl[16] = mk(0, 2'b00, 1, 5'b10010);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].t, tbl[i].e);
      chk($sformatf("tbl_%0d", i), w_out, tbl[i].exp);
    end

    // ---- PULSE scenario from level 0 ----
    do_reset();
    pulse_scn("pulse");

    // ---- TOGGLE with en every other cycle ----
    step(1'b1, 2'b10, 1'b0);
    chk("tog_half_c1", w_out, 5'b11001);
    for (int c = 1; c <= 8; c++) begin
      step(1'b0, 2'b00, (c % 2) == 0);
      exp = (c == 8) ? 5'b10010 : 5'b10001;
      chk($sformatf("tog_half_c%0d", c + 1), w_out, exp);
    end

    // ---- back-to-back TOGGLEs with valid held high ----
    do_reset();
    for (int c = 0; c < 15; c++) begin
      int n;
      n = c + 1;
      step(c <= 10, 2'b10, 1'b1);
      exp = {(n < 6) || (n >= 11), (n == 1) || (n == 11), n == 6,
             (n == 5) || (n == 10) || (n == 15), !((n == 5) || (n == 10) || (n == 15))};
      chk($sformatf("b2b_c%0d", n), w_out, exp);
    end

    // ---- async reset in cycle 2 of a PULSE ----
    do_reset();
    step(1'b1, 2'b11, 1'b1);
    step(1'b0, 2'b00, 1'b1);
    chk("mid_pulse_c2", w_out, 5'b10001);
    rst = 1'b1;
    #1;
    chk("rst_async", w_out, 5'b00010);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 2'b00, 1'b1);
    chk("rst_after", w_out, 5'b00010);
    pulse_scn("pulse_after_rst");

    // ---- randomized traffic against the reference model ----
    do_reset();
    m_left = 0; m_lvl = 1'b0; m_pulse = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 2) == 0);
      rt = 2'($urandom_range(0, 3));
      case (i / 1000)
        0:       re = 1'b1;
        1:       re = ($urandom_range(0, 3) != 0);
        default: re = ($urandom_range(0, 2) == 0);
      endcase
      prev = m_lvl;
      if (m_left == 0) begin
        if (rv) begin
          tgt = (rt == 2'b00) ? 1'b0 : (rt == 2'b01) ? 1'b1 : ~m_lvl;
          if (tgt != m_lvl) begin
            m_lvl   = tgt;
            m_pulse = (rt == 2'b11);
            m_left  = m_pulse ? 2 * H : H;
          end
        end
      end else if (re) begin
        m_left--;
        if (m_pulse && m_left == H) m_lvl = ~m_lvl;
      end
      step(rv, rt, re);
      exp = {m_lvl, m_lvl & ~prev, ~m_lvl & prev, m_left == 0, m_left != 0};
      chk($sformatf("rand_%0d", i), w_out, exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
